// File: rtl/sccomp_pkg.sv
// Shared types and widths for the instruction-memory loader: FSM state encoding,
// instruction word width and boot-header width.
package sccomp_pkg;

    localparam int WORD_W = 32;
    localparam int HDR_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_e;

endpackage

// File: rtl/word_asm.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module word_asm
    import sccomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_next_o,
    output logic              last_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    // Right shift: after four bytes the first byte sits in the least significant lane.
    assign word_next_o = {byte_i, word_q[WORD_W-1:BYTE_W]};
    assign last_o      = (cnt_q == 2'd3);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = word_next_o;
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a 16-bit word count followed by little-endian instruction
// words over a byte stream, writes them to instruction memory, then releases the core.
//
// state | meaning
// IDLE  | waiting for start, core held
// HDR0  | accept low byte of word count N
// HDR1  | accept high byte of N and validate it
// DATA  | assembling the next instruction word
// WRITE | one-cycle memory write of the assembled word
// DONE  | session completed, core released
// ERR   | bad header or byte timeout, core held
module imem_loader
    import sccomp_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [31:0] CAP     = 32'(1) << ADDR_W;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [HDR_W-1:0]  n_q, n_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              load_st;
    logic              xfer;
    logic [HDR_W-1:0]  hdr_n;
    logic              asm_clear;
    logic              asm_shift;
    logic [WORD_W-1:0] asm_word_next;
    logic              asm_last;

    assign load_st = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
    assign xfer    = rx_valid && load_st;
    assign hdr_n   = {rx_data, n_q[7:0]};

    word_asm u_word_asm (
        .clk         (clk),
        .rst         (rstn),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .byte_i      (rx_data),
        .word_next_o (asm_word_next),
        .last_o      (asm_last)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;

        if (load_st) begin
            tmo_d = xfer ? '0 : tmo_q + TMO_W'(1);
        end

        // Timeout wins over any byte arriving in the same cycle so a partial word is never written.
        if (load_st && (tmo_q == TMO_LIMIT)) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d   = ST_HDR0;
                        idx_d     = '0;
                        tmo_d     = '0;
                        asm_clear = 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (xfer) begin
                        n_d[7:0] = rx_data;
                        state_d  = ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (xfer) begin
                        n_d = hdr_n;
                        if (hdr_n == '0) begin
                            state_d = ST_DONE;
                        end else if (32'(hdr_n) > CAP) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        asm_shift = 1'b1;
                        if (asm_last) begin
                            state_d = ST_WRITE;
                            addr_d  = idx_q;
                            wdata_d = asm_word_next;
                        end
                    end
                end
                ST_WRITE: begin
                    idx_d = idx_q + ADDR_W'(1);
                    if ((32'(idx_q) + 32'd1) == 32'(n_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rx_ready   = load_st;
    assign imem_we    = (state_q == ST_WRITE);
    assign busy       = load_st || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign cpu_hold   = (state_q != ST_DONE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams are queued, expected memory writes go
// to a scoreboard that a write monitor drains.
module tb_imem_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 40;

    logic              clk;
    logic              rstn;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;

    logic [7:0]        tx_q[$];
    logic [39:0]       sb[$];

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", imem_addr, imem_wdata);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e[39:32]));
                chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic push_hdr(input logic [15:0] n);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [7:0] a, input logic [31:0] w);
        sb.push_back({a, w});
        tx_q.push_back(w[7:0]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[31:24]);
    endtask

    // Streams tx_q with rx_valid held high throughout, including WRITE cycles.
    task automatic stream();
        int n;
        @(negedge clk);
        while (tx_q.size() > 0) begin
            rx_valid = 1'b1;
            rx_data  = tx_q[0];
            n = 0;
            while (rx_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (rx_ready !== 1'b1) begin
                chk("handshake_timeout", 64'(n), 64'(0));
                tx_q.delete();
            end else begin
                @(posedge clk);
                #1;
                void'(tx_q.pop_front());
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && err !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int wr_before;
        rstn = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;

        // Reset values while reset is asserted, before any clock edge.
        #2;
        chk("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        chk("rst_rx_ready", 64'(rx_ready), 64'(0));
        chk("rst_imem_we", 64'(imem_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(0));
        chk("rst_wdata", 64'(imem_wdata), 64'(0));
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_rx_ready", 64'(rx_ready), 64'(0));

        // Two-word program.
        do_start();
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_rx_ready", 64'(rx_ready), 64'(1));
        push_hdr(16'd2);
        push_word(8'd0, 32'h0000_0013);
        push_word(8'd1, 32'h0010_0093);
        stream();
        wait_end(20);
        chk("prog_done", 64'(done), 64'(1));
        chk("prog_err", 64'(err), 64'(0));
        chk("prog_cpu_hold", 64'(cpu_hold), 64'(0));
        chk("prog_busy", 64'(busy), 64'(0));
        chk("prog_sb_empty", 64'(sb.size()), 64'(0));
        chk("hold_addr", 64'(imem_addr), 64'(1));
        chk("hold_wdata", 64'(imem_wdata), 64'h0010_0093);

        // Empty program: straight to DONE, no write; start from DONE re-holds the core.
        wr_before = wr_count;
        do_start();
        chk("restart_cpu_hold", 64'(cpu_hold), 64'(1));
        chk("restart_done_clr", 64'(done), 64'(0));
        push_hdr(16'd0);
        stream();
        wait_end(4);
        chk("empty_done", 64'(done), 64'(1));
        chk("empty_cpu_hold", 64'(cpu_hold), 64'(0));
        chk("empty_no_write", 64'(wr_count), 64'(wr_before));

        // Oversize header N = 257.
        wr_before = wr_count;
        do_start();
        push_hdr(16'd257);
        stream();
        wait_end(6);
        chk("big_err", 64'(err), 64'(1));
        chk("big_done", 64'(done), 64'(0));
        chk("big_cpu_hold", 64'(cpu_hold), 64'(1));
        chk("big_no_write", 64'(wr_count), 64'(wr_before));

        // Byte timeout with a partial word pending.
        wr_before = wr_count;
        do_start();
        chk("err_clr_on_start", 64'(err), 64'(0));
        push_hdr(16'd1);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        stream();
        chk("tmo_busy_mid", 64'(busy), 64'(1));
        wait_end(TIMEOUT + 20);
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_busy", 64'(busy), 64'(0));
        chk("tmo_no_write", 64'(wr_count), 64'(wr_before));

        // Full-capacity load, N = 256, last index 255.
        do_start();
        push_hdr(16'd256);
        for (int i = 0; i < 256; i++) begin
            push_word(8'(i), {8'(i), 8'(255 - i), 8'(i ^ 8'h5A), 8'(i + 3)});
        end
        stream();
        wait_end(20);
        chk("cap_done", 64'(done), 64'(1));
        chk("cap_sb_empty", 64'(sb.size()), 64'(0));
        chk("cap_last_addr", 64'(imem_addr), 64'(255));

        // Reset pulse in the middle of DATA, then a clean reload from address 0.
        wr_before = wr_count;
        do_start();
        push_hdr(16'd2);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        stream();
        #2;
        rstn = 1'b1;
        #1;
        chk("midrst_cpu_hold", 64'(cpu_hold), 64'(1));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_rx_ready", 64'(rx_ready), 64'(0));
        chk("midrst_imem_we", 64'(imem_we), 64'(0));
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'(0));
        chk("midrst_no_write", 64'(wr_count), 64'(wr_before));
        do_start();
        push_hdr(16'd3);
        push_word(8'd0, 32'hDEAD_BEEF);
        push_word(8'd1, 32'h0123_4567);
        push_word(8'd2, 32'h89AB_CDEF);
        stream();
        wait_end(20);
        chk("reload_done", 64'(done), 64'(1));
        chk("reload_sb_empty", 64'(sb.size()), 64'(0));
        chk("reload_writes", 64'(wr_count), 64'(wr_before + 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
